sensor_frame_rx: RTL and testbench



---
 rtl/sensor_frame_rx.sv | 92 +++++++++
 tb/tb_sensor_frame_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_frame_rx.sv
// Serial framed-word receiver: start/payload/parity/stop deserializer feeding the
// memory unit with din plus a one-cycle write enable; bad or stalled frames are flagged.
module sensor_frame_rx #(
  parameter int DATA_W  = 35,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic [DATA_W-1:0] dout,
  output logic              wren,
  output logic              frame_err,
  output logic              busy,
  output logic [7:0]        good_cnt
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [5:0] LAST_BIT = 6'(DATA_W - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_sr;
  logic [5:0]        bit_cnt;
  logic [7:0]        idle_cnt;
  logic              parity_ok;
  logic              wren_d, err_d;
  logic              timeout;
  logic              start_hit;

  // A strobe in the same cycle always beats the timeout
  assign timeout   = (state_q != IDLE) && !bit_valid && (idle_cnt == TO_LAST);
  assign start_hit = (state_q == IDLE) && bit_valid && bit_in;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    wren_d  = 1'b0;
    err_d   = 1'b0;
    if (timeout) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else if (bit_valid) begin
      case (state_q)
        IDLE:    if (bit_in) state_d = DATA;
        DATA:    if (bit_cnt == LAST_BIT) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP: begin
          state_d = IDLE;
          if (!bit_in && parity_ok) wren_d = 1'b1;
          else                      err_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control and output register stage
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= IDLE;
      bit_cnt   <= '0;
      idle_cnt  <= '0;
      parity_ok <= 1'b0;
      wren      <= 1'b0;
      frame_err <= 1'b0;
      good_cnt  <= '0;
      dout      <= '0;
    end else begin
      state_q   <= state_d;
      wren      <= wren_d;
      frame_err <= err_d;
      if (wren_d) begin
        dout     <= shift_sr;
        good_cnt <= good_cnt + 8'd1;
      end
      if ((state_q == IDLE) || bit_valid || timeout) idle_cnt <= '0;
      else                                           idle_cnt <= idle_cnt + 8'd1;
      if (start_hit)                          bit_cnt <= '0;
      else if ((state_q == DATA) && bit_valid) bit_cnt <= bit_cnt + 6'd1;
      if ((state_q == PARITY) && bit_valid) parity_ok <= (bit_in == ^shift_sr);
    end
  end

  // Payload shift register; cleared by every start bit so it needs no reset
  always_ff @(posedge clk) begin
    if (start_hit)                          shift_sr <= '0;
    else if ((state_q == DATA) && bit_valid) shift_sr <= {shift_sr[DATA_W-2:0], bit_in};
  end

endmodule

// File: tb/tb_sensor_frame_rx.sv
// Randomized scoreboard bench for sensor_frame_rx: the driver predicts each frame outcome
// from the framing rules and a monitor compares every wren/frame_err pulse against it.
module tb_sensor_frame_rx;

  localparam int DW = 35;
  localparam int TO = 255;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic          bit_valid = 1'b0;
  logic          bit_in = 1'b0;
  logic [DW-1:0] dout;
  logic          wren;
  logic          frame_err;
  logic          busy;
  logic [7:0]    good_cnt;

  sensor_frame_rx #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .arst(arst), .bit_valid(bit_valid), .bit_in(bit_in),
    .dout(dout), .wren(wren), .frame_err(frame_err), .busy(busy), .good_cnt(good_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          is_wr;
    logic [DW-1:0] data;
    logic [7:0]    cnt;
    int            cyc;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;
  bit            busy_chk = 0;
  logic [DW-1:0] model_dout = '0;
  logic [7:0]    model_cnt = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every output pulse must match the oldest predicted outcome
  always @(negedge clk) begin
    if (!arst && (wren || frame_err)) begin
      chk("wren_err_exclusive", {63'd0, wren & frame_err}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {62'd0, wren, frame_err}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pulse_kind_wren", {63'd0, wren}, {63'd0, mon_e.is_wr});
        chk("dout", 64'(dout), 64'(mon_e.data));
        chk("good_cnt", 64'(good_cnt), 64'(mon_e.cnt));
        chk("pulse_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic quiet(input int n);
    repeat (n) begin
      @(negedge clk);
      bit_valid = 1'b0;
      bit_in    = 1'($urandom);
    end
  endtask

  task automatic strobe(input logic b, input int gap);
    repeat (gap) begin
      @(negedge clk);
      if (busy_chk) chk("busy_in_gap", {63'd0, busy}, 64'd1);
      bit_valid = 1'b0;
      bit_in    = 1'($urandom);
    end
    @(negedge clk);
    bit_valid = 1'b1;
    bit_in    = b;
  endtask

  task automatic push_exp(input logic is_wr, input int at_cyc);
    exp_t e;
    e.is_wr = is_wr;
    e.data  = model_dout;
    e.cnt   = model_cnt;
    e.cyc   = at_cyc;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [DW-1:0] p, input logic par, input logic stp,
                            input int gap, input bit watch_busy);
    busy_chk = 0;
    strobe(1'b1, gap);
    busy_chk = watch_busy;
    for (int i = DW - 1; i >= 0; i--) strobe(p[i], gap);
    strobe(par, gap);
    strobe(stp, gap);
    busy_chk = 0;
    if ((par == ^p) && !stp) begin
      model_dout = p;
      model_cnt  = model_cnt + 8'd1;
      push_exp(1'b1, cyc + 1);
    end else begin
      push_exp(1'b0, cyc + 1);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    arst = 1'b1;
    bit_valid = 1'b0;
    #1;
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_wren", {63'd0, wren}, 64'd0);
    chk("rst_frame_err", {63'd0, frame_err}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_good_cnt", 64'(good_cnt), 64'd0);
    exp_q.delete();
    model_cnt  = '0;
    model_dout = '0;
    @(negedge clk);
    arst = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] p;
    int            kind;
    int            last_cyc;
    int            w;

    repeat (3) @(negedge clk);
    apply_reset();
    quiet(2);

    send_frame(35'h4_0000_0001, 1'b0, 1'b0, 0, 1);
    quiet(3);
    chk("busy_after_frame", {63'd0, busy}, 64'd0);

    send_frame(35'h7_FFFF_FFFF, 1'b1, 1'b0, 3, 1);
    quiet(3);

    send_frame(35'h1234, 1'b1, 1'b0, 0, 0);
    send_frame(35'h5, 1'b1, 1'b0, 0, 0);
    quiet(3);

    send_frame(35'h2_4680_1357, ^35'h2_4680_1357, 1'b1, 0, 0);
    strobe(1'b0, 1);
    send_frame(35'h0_0ABC_DEF0, ^35'h0_0ABC_DEF0, 1'b0, 1, 0);
    quiet(3);

    // Stall after ten payload bits; the frame must be aborted exactly TO cycles later
    strobe(1'b1, 0);
    for (int i = 0; i < 10; i++) strobe(1'($urandom), 0);
    last_cyc = cyc;
    push_exp(1'b0, last_cyc + 1 + TO);
    quiet(TO);
    chk("busy_before_timeout", {63'd0, busy}, 64'd1);
    quiet(1);
    chk("busy_after_timeout", {63'd0, busy}, 64'd0);
    quiet(2);

    // A strobe arriving 254 cycles after the previous one keeps the frame alive
    p = 35'h3_1415_9265;
    strobe(1'b1, 0);
    for (int i = DW - 1; i >= DW - 10; i--) strobe(p[i], 0);
    strobe(p[DW-11], 253);
    for (int i = DW - 12; i >= 0; i--) strobe(p[i], 0);
    strobe(^p, 0);
    strobe(1'b0, 0);
    model_dout = p;
    model_cnt  = model_cnt + 8'd1;
    push_exp(1'b1, cyc + 1);
    quiet(3);

    for (int n = 0; n < 40; n++) begin
      p    = DW'({$urandom, $urandom});
      kind = $urandom_range(0, 5);
      if ($urandom_range(0, 3) == 0) strobe(1'b0, $urandom_range(0, 2));
      send_frame(p, (kind == 0) ? ~(^p) : ^p, (kind == 1), $urandom_range(0, 2), 1);
      if ($urandom_range(0, 1) == 0) quiet($urandom_range(1, 20));
    end
    quiet(3);

    // Asynchronous reset while payload bit 20 is on the line
    strobe(1'b1, 0);
    for (int i = 0; i < 20; i++) strobe(1'($urandom), 0);
    #2;
    arst = 1'b1;
    #1;
    chk("arst_mid_dout", 64'(dout), 64'd0);
    chk("arst_mid_wren", {63'd0, wren}, 64'd0);
    chk("arst_mid_frame_err", {63'd0, frame_err}, 64'd0);
    chk("arst_mid_busy", {63'd0, busy}, 64'd0);
    chk("arst_mid_good_cnt", 64'(good_cnt), 64'd0);
    exp_q.delete();
    model_cnt  = '0;
    model_dout = '0;
    @(negedge clk);
    bit_valid = 1'b0;
    arst      = 1'b0;
    quiet(2);
    send_frame(35'h6_DEAD_BEEF, ^35'h6_DEAD_BEEF, 1'b0, 0, 1);
    quiet(3);

    apply_reset();
    quiet(1);
    for (int n = 0; n < 256; n++) begin
      p = DW'({$urandom, $urandom});
      send_frame(p, ^p, 1'b0, 0, 0);
    end
    quiet(3);
    chk("good_cnt_wrap", 64'(good_cnt), 64'd0);

    w = 0;
    while (exp_q.size() > 0 && w < 600) begin
      @(negedge clk);
      w++;
    end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
